// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch FSM encoding, the buffered {pc, inst} entry and PC helpers.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        KADDR = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [63:0] PC_STEP    = 64'd4;
    localparam logic [1:0]  FIFO_DEPTH = 2'd2;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, inst} words between the bus and decode.
// Flush wins over push and pop; a simultaneous push and pop is allowed even when full.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // When full, the slot freed by the pop is the one the write pointer lands on.
    assign do_push = push && ((count != FIFO_DEPTH) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding bus read, 2-entry buffer to decode,
// and redirect handling that kills in-flight work and restarts at the branch target.
//
// state | meaning
// IDLE  | no request presented; waiting for buffer room
// ADDR  | request for pc presented on the bus
// DATA  | request accepted; waiting for its response
// KADDR | killed request still presented, address held until accepted
// DRAIN | killed request accepted; waiting to discard its response
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ibus_req_valid,
    output logic [63:0] ibus_req_addr,
    input  logic        ibus_req_ready,
    input  logic        ibus_resp_valid,
    input  logic [31:0] ibus_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    input  logic        out_ready
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [63:0]  pc;
    logic [63:0]  inflight_pc;

    fetch_entry_t fifo_head;
    fetch_entry_t fifo_push_entry;
    logic [1:0]   fifo_count;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    logic [1:0]   count_after_pop;
    logic [1:0]   count_after_push_pop;

    // A redirect flushes the buffer and overrides any same-cycle push or pop.
    assign fifo_flush = redirect_valid;
    assign fifo_pop   = out_valid && out_ready && !redirect_valid;
    assign fifo_push  = (state == DATA) && ibus_resp_valid && !redirect_valid;

    assign fifo_push_entry.pc   = inflight_pc;
    assign fifo_push_entry.inst = ibus_resp_data;

    // In DATA the buffer holds at most one entry, so the sum never exceeds 2.
    assign count_after_pop      = fifo_count - {1'b0, fifo_pop};
    assign count_after_push_pop = count_after_pop + {1'b0, fifo_push};

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (reset),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_entry (fifo_push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= align_pc(RESET_PC);
            inflight_pc <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc <= align_pc(redirect_pc);
            end else if ((state == ADDR) && ibus_req_ready) begin
                pc <= pc + PC_STEP;
            end
            // Also captured on a kill so KADDR keeps presenting the original address.
            if ((state == ADDR) && (ibus_req_ready || redirect_valid)) begin
                inflight_pc <= pc;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && (count_after_pop < FIFO_DEPTH)) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (redirect_valid) begin
                    state_next = ibus_req_ready ? DRAIN : KADDR;
                end else if (ibus_req_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (redirect_valid) begin
                    state_next = ibus_resp_valid ? IDLE : DRAIN;
                end else if (ibus_resp_valid) begin
                    state_next = (count_after_push_pop < FIFO_DEPTH) ? ADDR : IDLE;
                end
            end
            KADDR: begin
                if (ibus_req_ready) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (ibus_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ibus_req_valid = 1'b0;
        ibus_req_addr  = '0;
        unique case (state)
            ADDR: begin
                ibus_req_valid = 1'b1;
                ibus_req_addr  = pc;
            end
            KADDR: begin
                ibus_req_valid = 1'b1;
                ibus_req_addr  = inflight_pc;
            end
            default: begin
                ibus_req_valid = 1'b0;
                ibus_req_addr  = '0;
            end
        endcase
    end

    assign out_valid = (fifo_count != 2'd0);
    assign out_inst  = out_valid ? fifo_head.inst : '0;
    assign out_pc    = out_valid ? fifo_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a bus/redirect driver predicts the
// instruction stream decode should see, and a monitor checks every handshake.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibus_req_valid;
    logic [63:0] ibus_req_addr;
    logic        ibus_req_ready = 1'b0;
    logic        ibus_resp_valid = 1'b0;
    logic [31:0] ibus_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .ibus_req_valid  (ibus_req_valid),
        .ibus_req_addr   (ibus_req_addr),
        .ibus_req_ready  (ibus_req_ready),
        .ibus_resp_valid (ibus_resp_valid),
        .ibus_resp_data  (ibus_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int delivered = 0;

    typedef struct {
        logic [63:0] addr;
        bit          live;
    } bus_req_t;

    bus_req_t     pend_q[$];
    fetch_entry_t exp_q[$];

    int          p_ready = 100;
    int          p_oready = 100;
    int          p_resp = 100;
    int          p_redir = 0;
    int          arm_mode = 0;
    logic [63:0] arm_tgt = '0;
    bit          force_data_en = 0;
    logic [31:0] force_data = '0;

    logic [63:0] exp_addr = RST_PC;
    logic [63:0] held_addr = '0;
    bit          presenting = 0;
    bit          live_req = 0;

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver and bus model: issues stimulus and predicts what decode must receive.
    always @(negedge clk) begin : drv
        bit          rdy;
        bit          rsp;
        bit          rdr;
        bit          ordy;
        logic [63:0] tgt;
        logic [31:0] dat;
        bus_req_t    b;
        if (reset) begin
            pend_q.delete();
            exp_q.delete();
            exp_addr        = RST_PC;
            presenting      = 0;
            live_req        = 0;
            ibus_req_ready  = 1'b0;
            ibus_resp_valid = 1'b0;
            ibus_resp_data  = '0;
            redirect_valid  = 1'b0;
            redirect_pc     = '0;
            out_ready       = 1'b0;
        end else begin
            if (ibus_req_valid) begin
                check("one_outstanding", 64'(pend_q.size()), 64'd0);
                if (presenting) begin
                    check("req_stable", ibus_req_addr, held_addr);
                end else begin
                    check("req_addr", ibus_req_addr, exp_addr);
                    live_req = 1;
                end
            end
            rdy  = roll(p_ready);
            ordy = roll(p_oready);
            rsp  = (pend_q.size() > 0) && roll(p_resp);
            rdr  = roll(p_redir);
            case ($urandom_range(3))
                0:       tgt = {$urandom, $urandom};
                1:       tgt = 64'h8000_0000 + 64'($urandom_range(255));
                2:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
                default: tgt = exp_addr;
            endcase
            case (arm_mode)
                1: if (ibus_req_valid && !rdy) begin rdr = 1; tgt = arm_tgt; arm_mode = 0; end
                2: if ((pend_q.size() > 0) && !rsp) begin rdr = 1; tgt = arm_tgt; arm_mode = 0; end
                3: if (rsp && ordy && out_valid) begin rdr = 1; tgt = arm_tgt; arm_mode = 0; end
                4: begin rdr = 1; tgt = arm_tgt; arm_mode = 0; end
                default: ;
            endcase
            dat = force_data_en ? force_data : $urandom;

            if (rsp) begin
                b = pend_q.pop_front();
                if (b.live && !rdr) exp_q.push_back('{pc: b.addr, inst: dat});
            end
            if (ibus_req_valid && rdy) begin
                pend_q.push_back('{addr: ibus_req_addr, live: live_req && !rdr});
                if (live_req && !rdr) exp_addr = exp_addr + 64'd4;
                live_req = 0;
            end
            presenting = ibus_req_valid && !rdy;
            held_addr  = ibus_req_addr;
            if (rdr) begin
                exp_addr = tgt & ~64'h3;
                live_req = 0;
                foreach (pend_q[i]) pend_q[i].live = 0;
                exp_q.delete();
            end

            ibus_req_ready  = rdy;
            ibus_resp_valid = rsp;
            ibus_resp_data  = rsp ? dat : 32'($urandom);
            redirect_valid  = rdr;
            redirect_pc     = tgt;
            out_ready       = ordy;
        end
    end

    // Monitor: pops the expected stream on each decode handshake.
    bit          prev_valid = 0;
    logic [63:0] prev_pc = '0;
    logic [31:0] prev_inst = '0;

    always @(posedge clk) begin : mon
        fetch_entry_t e;
        #1;
        if (reset) begin
            check("rst_req_valid", 64'(ibus_req_valid), 64'd0);
            check("rst_req_addr", ibus_req_addr, 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_inst", 64'(out_inst), 64'd0);
            check("rst_out_pc", out_pc, 64'd0);
            prev_valid = 0;
        end else begin
            if (prev_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h inst %h expected none", prev_pc, prev_inst);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", prev_pc, e.pc);
                    check("out_inst", 64'(prev_inst), 64'(e.inst));
                    delivered++;
                end
            end
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            prev_valid = out_valid;
            prev_pc    = out_pc;
            prev_inst  = out_inst;
        end
    end

    task automatic wait_fire(input string name);
        for (int i = 0; i < 300 && arm_mode != 0; i++) @(negedge clk);
        vectors++;
        if (arm_mode != 0) begin
            errors++;
            $display("FAIL %s: redirect condition not reached, got mode %0d expected 0", name, arm_mode);
            arm_mode = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Ideal bus, decode always ready.
        p_ready = 100; p_oready = 100; p_resp = 100; p_redir = 0;
        repeat (20) @(negedge clk);

        // Decode stalls: buffer fills, no further requests.
        p_oready = 0;
        repeat (10) @(negedge clk);
        #2;
        check("stall_req_valid", 64'(ibus_req_valid), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        p_oready = 100;
        repeat (10) @(negedge clk);

        // Redirect while waiting for data; the late DEADBEEF word must be dropped.
        p_resp = 0; arm_tgt = 64'h8000_0100; arm_mode = 2;
        wait_fire("redir_data");
        repeat (2) @(negedge clk);
        force_data_en = 1; force_data = 32'hDEAD_BEEF; p_resp = 100;
        repeat (3) @(negedge clk);
        force_data_en = 0;
        repeat (10) @(negedge clk);

        // Redirect while the request is stalled on the bus.
        p_ready = 0; arm_tgt = 64'h8000_0203; arm_mode = 1;
        wait_fire("redir_addr");
        repeat (3) @(negedge clk);
        p_ready = 100;
        repeat (15) @(negedge clk);

        // Redirect coinciding with a response and a decode pop.
        p_oready = 50; arm_tgt = 64'h8000_0440; arm_mode = 3;
        wait_fire("redir_resp_pop");
        p_oready = 100;
        repeat (15) @(negedge clk);

        // PC wrap at the top of the address space.
        arm_tgt = 64'hFFFF_FFFF_FFFF_FFFC; arm_mode = 4;
        wait_fire("redir_wrap");
        repeat (20) @(negedge clk);

        // Random mix of bus backpressure, latency, decode stalls and redirects.
        p_ready = 60; p_oready = 60; p_resp = 50; p_redir = 5;
        repeat (3000) @(negedge clk);

        // Reset in the middle of traffic.
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        p_ready = 100; p_oready = 100; p_resp = 100; p_redir = 0;
        repeat (30) @(negedge clk);

        vectors++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL progress: got %0d deliveries expected at least 100", delivered);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the RV64 pipeline: it is the consumer of the execute stage's branch-taken flag and target. It holds the PC and issues one instruction-bus read at a time. Fetched words go into a 2-entry buffer that feeds decode through a valid/ready handshake. When execute signals a taken branch or jump, the unit flushes the buffer, discards any in-flight response and restarts fetch at the new target.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ibus_req_valid  out  1  read request valid.
- ibus_req_addr  out  64  read address; low two bits always 0.
- ibus_req_ready  in  1  request accepted this cycle.
- ibus_resp_valid  in  1  read data valid; exactly one per accepted request, in order.
- ibus_resp_data  in  32  instruction word.
- redirect_valid  in  1  taken branch or jump from execute; single-cycle pulse.
- redirect_pc  in  64  new fetch address; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  buffered instruction available to decode.
- out_inst  out  32  instruction at buffer head.
- out_pc  out  64  PC of out_inst.
- out_ready  in  1  decode accepts head this cycle.

## Operation
- Registers: pc (next request address), inflight_pc (address of outstanding request), FSM state, and a 2-entry FIFO of {pc, inst}.
- FSM states:
  - IDLE: no request. Go to ADDR when the FIFO count after this cycle's pop is <2.
  - ADDR: ibus_req_valid=1, ibus_req_addr=pc. On ibus_req_ready: inflight_pc<=pc, pc<=pc+4, go to DATA.
  - DATA: waiting for the response. On ibus_resp_valid: push {inflight_pc, ibus_resp_data}. Then go to ADDR if the FIFO count after push and pop is <2, otherwise IDLE.
  - KADDR: killed request, still presented on the bus, with address unchanged. On ibus_req_ready go to DRAIN. Here pc is not incremented.
  - DRAIN: waiting for the killed response. On ibus_resp_valid, discard the data and go to IDLE.
- Redirect (redirect_valid=1), all sub-rules the same cycle:
  - FIFO is flushed and pc<=redirect_pc & ~3.
  - State transitions on redirect:
    - IDLE->IDLE.
    - ADDR without ready -> KADDR.
    - ADDR with ready -> DRAIN.
    - DATA without resp -> DRAIN.
    - DATA with resp -> IDLE; the response is discarded.
    - KADDR and DRAIN keep their normal transitions; only pc is updated.
- A redirect overrides a simultaneous pop and a simultaneous push.
- At most one request is outstanding. A request is issued only when the FIFO can absorb its response, so a push never meets a full FIFO.
- out_valid = FIFO non-empty; head pops on out_valid && out_ready.
- pc arithmetic is 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

## Timing
- Reset, asynchronous: state=IDLE, pc=RESET_PC, FIFO empty. ibus_req_valid=0, ibus_req_addr=0, out_valid=0, out_inst=0, out_pc=0.
- First rising edge after reset release: IDLE->ADDR. ibus_req_valid=1 with addr RESET_PC in the following cycle.
- ibus_req_valid and ibus_req_addr are FSM/register outputs, with no combinational path from any input. Once asserted, they stay stable until ibus_req_ready.
- Response to out_valid latency is 1 cycle: push on edge t, out_valid high from t+1.
- Redirect at edge t: out_valid=0 from t+1.
  - With no request outstanding, the request for the new target is presented at t+2 (IDLE, then ADDR).
- Minimum loop is IDLE->ADDR->DATA->ADDR: one instruction per 2 cycles at zero bus latency.
- Reset mid-transaction returns everything to reset values. The bus must drop any pending response under the same reset.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, ADDR, DATA, KADDR, DRAIN}.
  - fetch_entry_t struct {pc[63:0], inst[31:0]}.
  - PC_STEP = 4.
- Sub-module fetch_fifo, a 2-entry FIFO of fetch_entry_t:
  - Push/pop/flush ports; count output.
  - Flush has priority over push and pop.
  - Same-cycle push and pop are supported.

## Test plan
- Reset release, ibus_req_ready=1, response 1 cycle after accept -> requests at 8000_0000, 8000_0004, 8000_0008 in order. Decode receives matching out_pc and out_inst.
- out_ready=0 for 10 cycles -> buffer fills to 2 and ibus_req_valid stays 0. First out_ready=1 pops 8000_0000 and a new request for 8000_0008 follows.
- Redirect to 8000_0100 while in DATA, response arrives 3 cycles later with 0xDEADBEEF -> word discarded, out_valid stays 0. Next request addr is 8000_0100.
- Redirect to 8000_0203 while in ADDR with ibus_req_ready=0 -> ibus_req_addr stays unchanged until accepted, then its response is dropped. Next request addr is 8000_0200.
- Redirect in the same cycle as ibus_resp_valid and an out_ready pop -> FIFO empty next cycle. Next request is the redirect target.
- redirect_pc=FFFF_FFFF_FFFF_FFFC -> request at that address, then the following request addr is 0.
